// File: rtl/beamformer_seq_pkg.sv
// rtl/beamformer_seq_pkg.sv - shared types and default sizes for the beamformer run sequencer
//
// Contents:
//   seq_state_t          run controller states
//   DEF_*                default widths and run lengths used by the sequencer parameters
//   is_active()          true in the states where the beamformer is enabled
package beamformer_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    localparam int DEF_ADDR_W       = 11;
    localparam int DEF_IDX_W        = 16;
    localparam int DEF_NUM_SAMPLES  = 2048;
    localparam int DEF_DRAIN_CYCLES = 64;

    function automatic logic is_active(input seq_state_t s);
        return (s == RUN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/out_addr_tracker.sv
// rtl/out_addr_tracker.sv - output RAM address/count tracking driven by beamformer data-valid pulses
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           start of a new run: zero address, count, overflow
//   active          beamformer enabled this cycle (RUN/DRAIN, not aborting)
//   freeze          abort cycle: hold address and count
//   bf_data_good    beamformer output-valid strobe
//   wren            output RAM write enable
//   out_addr        output RAM address owned by the run
//   out_count       outputs written in this run
//   full            out_count has reached NUM_SAMPLES
//   overflow        sticky: a pulse arrived after the RAM was full
module out_addr_tracker #(
    parameter int ADDR_W      = 11,
    parameter int NUM_SAMPLES = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              active,
    input  logic              freeze,
    input  logic              bf_data_good,
    output logic              wren,
    output logic [ADDR_W-1:0] out_addr,
    output logic [ADDR_W:0]   out_count,
    output logic              full,
    output logic              overflow
);

    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W+1)'(NUM_SAMPLES);
    localparam logic [ADDR_W:0] COUNT_LAST = (ADDR_W+1)'(NUM_SAMPLES - 1);

    // Registered copy of the strobe, only remembered while the run owns it, so a
    // pulse straddling the DRAIN->DONE boundary is still counted but stray pulses
    // in IDLE/DONE never create a fall.
    logic dg_q;
    logic dg_fall;
    logic dg_rise;

    assign full    = (out_count == COUNT_FULL);
    assign wren    = bf_data_good & active & ~full;
    assign dg_fall = dg_q & ~bf_data_good & ~full & ~freeze;
    assign dg_rise = bf_data_good & ~dg_q & active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dg_q      <= 1'b0;
            out_addr  <= '0;
            out_count <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            dg_q      <= 1'b0;
            out_addr  <= '0;
            out_count <= '0;
            overflow  <= 1'b0;
        end else begin
            dg_q <= bf_data_good & active;
            if (dg_fall) begin
                out_count <= out_count + 1'b1;
                // The last slot keeps its address so the final write stays visible.
                if (out_count < COUNT_LAST) begin
                    out_addr <= out_addr + 1'b1;
                end
            end
            if (dg_rise && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/beamformer_sequencer.sv
// rtl/beamformer_sequencer.sv - run controller and RAM address arbiter for the delay-and-sum beamformer
//
// Optional build macro: SEQ_WATCHDOG_EN adds a DRAIN watchdog and the sticky `timeout` output.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, abort                    run request / cancel (abort wins)
//   readinen, readin_address        host access to the input RAM address (IDLE/DONE only)
//   sumouten, sumout_address        host access to the output RAM address (IDLE/DONE only)
//   bf_data_good                    beamformer output-valid strobe
//   in_ram_addr                     input signal RAM address
//   bf_start, bf_index              beamformer enable and 1-based sample index
//   out_ram_addr, out_ram_wren      output signal RAM address and write enable
//   busy, done                      PRIME/RUN/DRAIN, DONE
//   out_count, overflow             outputs written, sticky write-past-end flag
//   timeout                         (SEQ_WATCHDOG_EN only) DRAIN watchdog expired
module beamformer_sequencer
    import beamformer_seq_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int IDX_W        = DEF_IDX_W,
    parameter int NUM_SAMPLES  = DEF_NUM_SAMPLES,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              readinen,
    input  logic [ADDR_W-1:0] readin_address,
    input  logic              sumouten,
    input  logic [ADDR_W-1:0] sumout_address,
    input  logic              bf_data_good,
    output logic [ADDR_W-1:0] in_ram_addr,
    output logic              bf_start,
    output logic [IDX_W-1:0]  bf_index,
    output logic [ADDR_W-1:0] out_ram_addr,
    output logic              out_ram_wren,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   out_count,
    output logic              overflow
`ifdef SEQ_WATCHDOG_EN
    ,
    output logic              timeout
`endif
);

    localparam int                DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [ADDR_W-1:0] SEQ_LAST   = ADDR_W'(NUM_SAMPLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    seq_state_t          state;
    seq_state_t          state_nxt;
    logic [ADDR_W-1:0]   seq_addr;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [ADDR_W-1:0]   out_addr;
    logic                start_accept;
    logic                host_sel;
    logic                drain_exit;
    logic                out_full;

`ifdef SEQ_WATCHDOG_EN
    logic [15:0] wd_cnt;
    logic        wd_dg_q;
    logic        wd_expired;

    assign wd_expired = (wd_cnt == 16'hFFFF);
    assign drain_exit = (drain_cnt == DRAIN_LAST) || wd_expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            wd_dg_q <= 1'b0;
            timeout <= 1'b0;
        end else begin
            wd_dg_q <= bf_data_good;
            if ((state != DRAIN) || (bf_data_good && !wd_dg_q)) begin
                wd_cnt <= '0;
            end else if (!wd_expired) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (start_accept) begin
                timeout <= 1'b0;
            end else if ((state == DRAIN) && wd_expired && !abort) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    assign drain_exit = (drain_cnt == DRAIN_LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        start_accept = 1'b0;
        bf_start     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        host_sel     = 1'b0;

        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_nxt    = PRIME;
                        start_accept = 1'b1;
                    end
                end
                PRIME:   state_nxt = RUN;
                RUN:     if (seq_addr == SEQ_LAST) state_nxt = DRAIN;
                DRAIN:   if (drain_exit) state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end

        bf_start = is_active(state) && !abort;
        busy     = (state == PRIME) || is_active(state);
        done     = (state == DONE);
        host_sel = (state == IDLE) || (state == DONE);
    end

    // Run counters. bf_index advances on every edge that lands in RUN/DRAIN, so the
    // PRIME->RUN edge produces 1 and an abort (next state IDLE) freezes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_addr  <= '0;
            bf_index  <= '0;
            drain_cnt <= '0;
        end else if (start_accept) begin
            seq_addr  <= '0;
            bf_index  <= '0;
            drain_cnt <= '0;
        end else begin
            if ((state == RUN) && !abort && (seq_addr != SEQ_LAST)) begin
                seq_addr <= seq_addr + 1'b1;
            end
            if (is_active(state_nxt)) begin
                bf_index <= bf_index + 1'b1;
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

    out_addr_tracker #(
        .ADDR_W      (ADDR_W),
        .NUM_SAMPLES (NUM_SAMPLES)
    ) u_out_addr_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (start_accept),
        .active       (bf_start),
        .freeze       (abort),
        .bf_data_good (bf_data_good),
        .wren         (out_ram_wren),
        .out_addr     (out_addr),
        .out_count    (out_count),
        .full         (out_full),
        .overflow     (overflow)
    );

    assign in_ram_addr  = (readinen && host_sel) ? readin_address : seq_addr;
    assign out_ram_addr = (sumouten && host_sel) ? sumout_address : out_addr;

endmodule

// File: tb/tb_beamformer_sequencer.sv
// tb/tb_beamformer_sequencer.sv - directed self-checking bench for beamformer_sequencer
module tb_beamformer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        readinen = 1'b0;
    logic [10:0] readin_address = '0;
    logic        sumouten = 1'b0;
    logic [10:0] sumout_address = '0;

    logic        start_a = 1'b0, abort_a = 1'b0, dg_a = 1'b0;
    logic [10:0] in_addr_a, out_addr_a;
    logic        bf_start_a, wren_a, busy_a, done_a, ovf_a;
    logic [15:0] bf_index_a;
    logic [11:0] count_a;

    logic        start_b = 1'b0, dg_b = 1'b0;
    logic [10:0] in_addr_b, out_addr_b;
    logic        bf_start_b, wren_b, busy_b, done_b, ovf_b;
    logic [15:0] bf_index_b;
    logic [11:0] count_b;

    logic        start_c = 1'b0;
    logic [10:0] in_addr_c, out_addr_c;
    logic        bf_start_c, wren_c, busy_c, done_c, ovf_c;
    logic [15:0] bf_index_c;
    logic [11:0] count_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    beamformer_sequencer #(.ADDR_W(11), .IDX_W(16), .NUM_SAMPLES(8), .DRAIN_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .readinen(readinen), .readin_address(readin_address),
        .sumouten(sumouten), .sumout_address(sumout_address),
        .bf_data_good(dg_a), .in_ram_addr(in_addr_a), .bf_start(bf_start_a),
        .bf_index(bf_index_a), .out_ram_addr(out_addr_a), .out_ram_wren(wren_a),
        .busy(busy_a), .done(done_a), .out_count(count_a), .overflow(ovf_a));

    beamformer_sequencer #(.ADDR_W(11), .IDX_W(16), .NUM_SAMPLES(4), .DRAIN_CYCLES(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0),
        .readinen(1'b0), .readin_address(11'd0),
        .sumouten(1'b0), .sumout_address(11'd0),
        .bf_data_good(dg_b), .in_ram_addr(in_addr_b), .bf_start(bf_start_b),
        .bf_index(bf_index_b), .out_ram_addr(out_addr_b), .out_ram_wren(wren_b),
        .busy(busy_b), .done(done_b), .out_count(count_b), .overflow(ovf_b));

    beamformer_sequencer dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .abort(1'b0),
        .readinen(1'b0), .readin_address(11'd0),
        .sumouten(1'b0), .sumout_address(11'd0),
        .bf_data_good(1'b0), .in_ram_addr(in_addr_c), .bf_start(bf_start_c),
        .bf_index(bf_index_c), .out_ram_addr(out_addr_c), .out_ram_wren(wren_c),
        .busy(busy_c), .done(done_c), .out_count(count_c), .overflow(ovf_c));

    task automatic test_reset;
        @(negedge clk); #1;
        checks++;
        if ({in_addr_a, bf_start_a, bf_index_a, out_addr_a, wren_a, busy_a, done_a, count_a, ovf_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: outputs=%h required 0",
                     {in_addr_a, bf_start_a, bf_index_a, out_addr_a, wren_a, busy_a, done_a, count_a, ovf_a});
        end
        checks++;
        if ({in_addr_b, bf_start_b, bf_index_b, out_addr_b, wren_b, busy_b, done_b, count_b, ovf_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: outputs=%h required 0",
                     {in_addr_b, bf_start_b, bf_index_b, out_addr_b, wren_b, busy_b, done_b, count_b, ovf_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_run;
        bit found = 1'b0;
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk); #1;
            if (in_addr_c == 11'd100) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midrun_reach: in_ram_addr=%0d never reached required 100", in_addr_c);
        end
        checks++;
        if ({busy_c, bf_start_c, bf_index_c} !== {1'b1, 1'b1, 16'd101}) begin
            errors++;
            $display("FAIL midrun_state: busy/bf_start/bf_index=%h required %h",
                     {busy_c, bf_start_c, bf_index_c}, {1'b1, 1'b1, 16'd101});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_addr_c, bf_start_c, bf_index_c, out_addr_c, wren_c, busy_c, done_c, count_c, ovf_c} !== '0) begin
            errors++;
            $display("FAIL midrun_async_reset: outputs=%h required 0",
                     {in_addr_c, bf_start_c, bf_index_c, out_addr_c, wren_c, busy_c, done_c, count_c, ovf_c});
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0; #1;
        checks++;
        if ({busy_c, bf_start_c, bf_index_c} !== {1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL restart_prime: busy/bf_start/bf_index=%h required %h",
                     {busy_c, bf_start_c, bf_index_c}, {1'b1, 1'b0, 16'd0});
        end
        @(negedge clk); #1;
        checks++;
        if ({bf_start_c, in_addr_c, bf_index_c} !== {1'b1, 11'd0, 16'd1}) begin
            errors++;
            $display("FAIL restart_run: bf_start/in_addr/bf_index=%h required %h",
                     {bf_start_c, in_addr_c, bf_index_c}, {1'b1, 11'd0, 16'd1});
        end
    endtask

    task automatic test_host_idle;
        @(negedge clk);
        readinen = 1'b1; readin_address = 11'h155;
        sumouten = 1'b1; sumout_address = 11'h02A;
        #1;
        checks++;
        if ({in_addr_a, out_addr_a} !== {11'h155, 11'h02A}) begin
            errors++;
            $display("FAIL host_idle: in/out addr=%h required %h", {in_addr_a, out_addr_a}, {11'h155, 11'h02A});
        end
        readinen = 1'b0; sumouten = 1'b0;
        #1;
        checks++;
        if ({in_addr_a, out_addr_a} !== 22'd0) begin
            errors++;
            $display("FAIL host_release: in/out addr=%h required 0", {in_addr_a, out_addr_a});
        end
    endtask

    task automatic test_run_sequence;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; #1;
        checks++;
        if ({busy_a, bf_start_a, in_addr_a, bf_index_a, done_a} !== {1'b1, 1'b0, 11'd0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL prime: busy/bf_start/in/idx/done=%h required %h",
                     {busy_a, bf_start_a, in_addr_a, bf_index_a, done_a}, {1'b1, 1'b0, 11'd0, 16'd0, 1'b0});
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start_a = (k == 3);
            #1;
            checks++;
            if ({busy_a, bf_start_a, in_addr_a, bf_index_a} !== {1'b1, 1'b1, 11'(k), 16'(k + 1)}) begin
                errors++;
                $display("FAIL run_k%0d: busy/bf_start/in/idx=%h required %h", k,
                         {busy_a, bf_start_a, in_addr_a, bf_index_a}, {1'b1, 1'b1, 11'(k), 16'(k + 1)});
            end
        end
        start_a = 1'b0;
        for (int d = 0; d < 4; d++) begin
            @(negedge clk); #1;
            checks++;
            if ({busy_a, bf_start_a, in_addr_a, bf_index_a} !== {1'b1, 1'b1, 11'd7, 16'(9 + d)}) begin
                errors++;
                $display("FAIL drain_d%0d: busy/bf_start/in/idx=%h required %h", d,
                         {busy_a, bf_start_a, in_addr_a, bf_index_a}, {1'b1, 1'b1, 11'd7, 16'(9 + d)});
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({busy_a, bf_start_a, done_a} !== 3'b001) begin
            errors++;
            $display("FAIL done_reached: busy/bf_start/done=%b required 001", {busy_a, bf_start_a, done_a});
        end
    endtask

    task automatic test_data_good;
        logic [10:0] exp_addr = '0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            dg_a = ((j % 4) < 2);
            #1;
            checks++;
            if ({wren_a, out_addr_a} !== {dg_a, exp_addr}) begin
                errors++;
                $display("FAIL dg_j%0d: wren/out_addr=%h required %h", j, {wren_a, out_addr_a}, {dg_a, exp_addr});
            end
            if ((j % 4) == 2) exp_addr++;
        end
        @(negedge clk); dg_a = 1'b1; #1;
        checks++;
        if ({done_a, wren_a, count_a, out_addr_a} !== {1'b1, 1'b0, 12'd3, 11'd3}) begin
            errors++;
            $display("FAIL dg_done: done/wren/count/addr=%h required %h",
                     {done_a, wren_a, count_a, out_addr_a}, {1'b1, 1'b0, 12'd3, 11'd3});
        end
        @(negedge clk); dg_a = 1'b0; #1;
        checks++;
        if ({count_a, out_addr_a} !== {12'd3, 11'd3}) begin
            errors++;
            $display("FAIL dg_ignored_in_done: count/addr=%h required %h", {count_a, out_addr_a}, {12'd3, 11'd3});
        end
    endtask

    task automatic test_host_and_abort;
        @(negedge clk);
        readinen = 1'b1; readin_address = 11'h155;
        sumouten = 1'b1; sumout_address = 11'h02A;
        #1;
        checks++;
        if ({in_addr_a, out_addr_a} !== {11'h155, 11'h02A}) begin
            errors++;
            $display("FAIL host_done: in/out addr=%h required %h", {in_addr_a, out_addr_a}, {11'h155, 11'h02A});
        end
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            checks++;
            if ({in_addr_a, out_addr_a} !== {11'(k), 11'd0}) begin
                errors++;
                $display("FAIL host_busy_k%0d: in/out addr=%h required %h", k, {in_addr_a, out_addr_a}, {11'(k), 11'd0});
            end
        end
        @(negedge clk);
        @(negedge clk);
        abort_a = 1'b1; dg_a = 1'b1;
        #1;
        checks++;
        if ({busy_a, bf_start_a, wren_a} !== 3'b100) begin
            errors++;
            $display("FAIL abort_cycle: busy/bf_start/wren=%b required 100", {busy_a, bf_start_a, wren_a});
        end
        @(negedge clk); abort_a = 1'b0; dg_a = 1'b0; #1;
        checks++;
        if ({busy_a, done_a, bf_start_a, in_addr_a, out_addr_a} !== {3'b000, 11'h155, 11'h02A}) begin
            errors++;
            $display("FAIL abort_idle: busy/done/bf_start/in/out=%h required %h",
                     {busy_a, done_a, bf_start_a, in_addr_a, out_addr_a}, {3'b000, 11'h155, 11'h02A});
        end
        readinen = 1'b0; sumouten = 1'b0; #1;
        checks++;
        if ({in_addr_a, bf_index_a, count_a} !== {11'd7, 16'd10, 12'd0}) begin
            errors++;
            $display("FAIL abort_hold: in/idx/count=%h required %h", {in_addr_a, bf_index_a, count_a}, {11'd7, 16'd10, 12'd0});
        end
        @(negedge clk); start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk); start_a = 1'b0; abort_a = 1'b0; #1;
        checks++;
        if ({busy_a, done_a, bf_start_a, bf_index_a} !== {3'b000, 16'd10}) begin
            errors++;
            $display("FAIL start_abort_idle: busy/done/bf_start/idx=%h required %h",
                     {busy_a, done_a, bf_start_a, bf_index_a}, {3'b000, 16'd10});
        end
    endtask

    task automatic test_overflow;
        logic [10:0] exp_addr = '0;
        int          exp_cnt = 0;
        logic        exp_ovf = 1'b0;
        logic        exp_wren;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            dg_b = ((j % 2) == 0);
            #1;
            exp_wren = dg_b && (exp_cnt < 4);
            checks++;
            if ({wren_b, out_addr_b, ovf_b} !== {exp_wren, exp_addr, exp_ovf}) begin
                errors++;
                $display("FAIL ovf_j%0d: wren/addr/ovf=%h required %h", j,
                         {wren_b, out_addr_b, ovf_b}, {exp_wren, exp_addr, exp_ovf});
            end
            if (dg_b && (exp_cnt == 4)) exp_ovf = 1'b1;
            if (((j % 2) == 1) && (exp_cnt < 4)) begin
                exp_cnt++;
                if (exp_cnt < 4) exp_addr++;
            end
        end
        dg_b = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({count_b, out_addr_b, ovf_b} !== {12'd4, 11'd3, 1'b1}) begin
            errors++;
            $display("FAIL ovf_final: count/addr/ovf=%h required %h", {count_b, out_addr_b, ovf_b}, {12'd4, 11'd3, 1'b1});
        end
    endtask

    initial begin
        test_reset;
        test_reset_mid_run;
        test_host_idle;
        test_run_sequence;
        test_data_good;
        test_host_and_abort;
        test_overflow;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL tb_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
